counter_snapshot_serializer: RTL and testbench

//   Downstream consumer of the 128-bit free-running counter. Samples the whole counter

---
 rtl/counter_pkg.sv | 21 ++
 rtl/counter_snapshot_serializer_if.sv | 12 +
 rtl/snap_shift_reg.sv | 27 ++
 rtl/counter_snapshot_serializer.sv | 71 +++++++
 tb/tb_counter_snapshot_serializer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the counter snapshot serializer.
// Holds the state encoding, default widths and the index-width helper.
package counter_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    localparam int CNT_W_DEF  = 128;
    localparam int WORD_W_DEF = 32;

    typedef enum logic {
        IDLE = ST_IDLE,
        SEND = ST_SEND
    } state_e;

    // A single-word snapshot still needs a 1-bit index.
    function automatic int idx_w(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/counter_snapshot_serializer_if.sv
// Narrow valid/ready word stream carrying one snapshot, LSB word first.
interface counter_snapshot_serializer_if #(
    parameter int WORD_W = counter_pkg::WORD_W_DEF
);
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input  out_ready);
    modport slave  (input  out_data, input  out_valid, input  out_last, output out_ready);
endinterface

// File: rtl/snap_shift_reg.sv
// Snapshot holding register: parallel load, right shift by one word, low word exposed.
module snap_shift_reg #(
    parameter int CNT_W  = 128,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              clr_ni,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [CNT_W-1:0]  din_i,
    output logic [WORD_W-1:0] word_o
);
    logic [CNT_W-1:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (load_i)       shadow_d = din_i;
        else if (shift_i) shadow_d = shadow_q >> WORD_W;
    end

    always_ff @(posedge clk) begin
        if (!clr_ni) shadow_q <= '0;
        else         shadow_q <= shadow_d;
    end

    assign word_o = shadow_q[WORD_W-1:0];
endmodule

// File: rtl/counter_snapshot_serializer.sv
// Captures the full counter in one cycle and streams it out a word at a time.
// Same clock domain as the counter; outputs are all register-decoded.
module counter_snapshot_serializer
    import counter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                               clk,
    input  logic                               resetb,
    input  logic [CNT_W-1:0]                   cnt_in,
    input  logic                               capture,
    counter_snapshot_serializer_if.master      stream,
    output logic                               busy,
    output logic                               overrun
);
    localparam int NWORDS = CNT_W / WORD_W;
    localparam int IDX_W  = idx_w(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    generate
        if (CNT_W % WORD_W != 0) begin : g_bad_width
            $error("CNT_W must be a multiple of WORD_W");
        end
    endgenerate

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             overrun_q;
    logic             accept, last, load, shift;

    assign accept = (state_q == SEND) && stream.out_ready;
    assign last   = (idx_q == LAST_IDX);

    // A capture coinciding with the final accept reloads without a bubble.
    always_comb begin
        load  = capture && ((state_q == IDLE) || (accept && last));
        shift = accept && !load;
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= capture && (state_q == SEND) && !(accept && last);
            if (load) begin
                state_q <= SEND;
                idx_q   <= '0;
            end else if (accept) begin
                if (last) state_q <= IDLE;
                else      idx_q   <= idx_q + 1'b1;
            end
        end
    end

    snap_shift_reg #(.CNT_W(CNT_W), .WORD_W(WORD_W)) u_shadow (
        .clk     (clk),
        .clr_ni  (resetb),
        .load_i  (load),
        .shift_i (shift),
        .din_i   (cnt_in),
        .word_o  (stream.out_data)
    );

    assign stream.out_valid = (state_q == SEND);
    assign stream.out_last  = (state_q == SEND) && last;
    assign busy             = (state_q == SEND);
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_counter_snapshot_serializer.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_counter_snapshot_serializer;
    logic         clk = 1'b0;
    logic         resetb;
    logic [127:0] cnt_in;
    logic         capture;
    logic         busy, overrun;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    counter_snapshot_serializer_if #(.WORD_W(32)) bus();

    counter_snapshot_serializer #(.CNT_W(128), .WORD_W(32)) dut (
        .clk     (clk),
        .resetb  (resetb),
        .cnt_in  (cnt_in),
        .capture (capture),
        .stream  (bus),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: words still owed to the consumer, front = on the bus now.
    logic [31:0] mq[$];
    bit          m_ov = 1'b0;

    always @(posedge clk) begin
        bit was_busy, acc, lst;
        if (!resetb) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            was_busy = (mq.size() > 0);
            acc      = was_busy && bus.out_ready;
            lst      = (mq.size() == 1);
            m_ov     = 1'b0;
            if (acc) void'(mq.pop_front());
            if (capture) begin
                if (!was_busy || (acc && lst))
                    for (int i = 0; i < 4; i++) mq.push_back(cnt_in[i*32 +: 32]);
                else
                    m_ov = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_valid",   128'(bus.out_valid), 128'(mq.size() > 0));
            chk("model_busy",    128'(busy),          128'(mq.size() > 0));
            chk("model_last",    128'(bus.out_last),  128'(mq.size() == 1));
            chk("model_overrun", 128'(overrun),       128'(m_ov));
            if (mq.size() > 0) chk("model_data", 128'(bus.out_data), 128'(mq[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] BASIC = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [31:0] words [4] = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    bit          pat   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [127:0] b_val;
        logic [31:0]  got[$];

        // Reset held with capture and ready high
        resetb = 1'b0; capture = 1'b1; bus.out_ready = 1'b1; cnt_in = rnd128();
        step();
        cmp_en = 1'b1;
        step(); step();
        chk("rst_valid",   128'(bus.out_valid), 128'd0);
        chk("rst_last",    128'(bus.out_last),  128'd0);
        chk("rst_busy",    128'(busy),          128'd0);
        chk("rst_overrun", 128'(overrun),       128'd0);
        chk("rst_data",    128'(bus.out_data),  128'd0);
        resetb = 1'b1; cnt_in = 128'hA5A5A5A5_0F0F0F0F_12345678_DEADBEEF;
        step();
        chk("post_rst_busy", 128'(busy),         128'd1);
        chk("post_rst_word", 128'(bus.out_data), 128'hDEADBEEF);
        capture = 1'b0;
        repeat (4) step();
        chk("post_rst_idle", 128'(busy), 128'd0);

        // Basic streaming at full rate
        cnt_in = BASIC; capture = 1'b1;
        step();
        capture = 1'b0; cnt_in = rnd128();
        for (int i = 0; i < 4; i++) begin
            chk("basic_word", 128'(bus.out_data), 128'(words[i]));
            chk("basic_last", 128'(bus.out_last), 128'(i == 3));
            chk("basic_busy", 128'(busy),         128'd1);
            step();
        end
        chk("basic_idle", 128'(busy), 128'd0);

        // Backpressure
        cnt_in = BASIC; capture = 1'b1;
        step();
        capture = 1'b0; cnt_in = rnd128();
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = pat[i];
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            step();
        end
        chk("bp_count", 128'(got.size()), 128'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("bp_word", 128'(got[i]), 128'(words[i]));
        chk("bp_idle", 128'(busy), 128'd0);
        bus.out_ready = 1'b1;

        // Overrun: captures on cycles 0 and 2
        cnt_in = 128'h11111111_22222222_33333333_44444444; capture = 1'b1;
        step();
        capture = 1'b0; cnt_in = rnd128();
        step();
        capture = 1'b1;
        step();
        chk("ovr_pulse", 128'(overrun),      128'd1);
        chk("ovr_word2", 128'(bus.out_data), 128'h22222222);
        capture = 1'b0;
        step();
        chk("ovr_clear", 128'(overrun), 128'd0);
        step();
        chk("ovr_idle", 128'(busy), 128'd0);

        // Back-to-back capture on the last accept
        cnt_in = rnd128(); capture = 1'b1;
        step();
        capture = 1'b0;
        repeat (3) step();
        b_val = rnd128(); cnt_in = b_val; capture = 1'b1;
        step();
        capture = 1'b0;
        chk("b2b_valid",   128'(bus.out_valid), 128'd1);
        chk("b2b_word0",   128'(bus.out_data),  128'(b_val[31:0]));
        chk("b2b_overrun", 128'(overrun),       128'd0);
        repeat (4) step();

        // Reset mid-stream
        cnt_in = rnd128(); capture = 1'b1;
        step();
        capture = 1'b0;
        step(); step();
        resetb = 1'b0;
        step();
        chk("mid_rst_valid", 128'(bus.out_valid), 128'd0);
        resetb = 1'b1; b_val = rnd128(); cnt_in = b_val; capture = 1'b1;
        step();
        capture = 1'b0;
        chk("mid_rst_word0", 128'(bus.out_data), 128'(b_val[31:0]));
        chk("mid_rst_last",  128'(bus.out_last), 128'd0);
        repeat (4) step();

        // Randomized traffic with rare resets
        for (int c = 0; c < 3000; c++) begin
            resetb        = ($urandom_range(0, 255) != 0);
            capture       = ($urandom_range(0, 7) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cnt_in        = rnd128();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
